sram_bus_arbiter: RTL and testbench

Shares one sram-like memory port between the instruction-fetch side (IF stage) and the data side (MEM stage) of the five-stage core. It grants one request per accepted address handshake, holds a grant until the address is accepted, and records the source of every accepted request in an order FIFO. Responses are returned to the side that issued them, in issue order. It sits between the core's `inst_sram_*`/`data_sram_*` request/response interfaces and the single memory or bridge port.

---
 rtl/sram_bus_arbiter_pkg.sv | 28 ++
 rtl/arb_order_fifo.sv | 49 ++++
 rtl/sram_bus_arbiter.sv | 121 ++++++++++++
 tb/tb_sram_bus_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bus_arbiter_pkg.sv
// Shared definitions for the IF/MEM sram-like port arbiter: source IDs,
// arbiter state encoding and request field widths.
package sram_bus_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SIZE_W = 2;
    localparam int STRB_W = 4;

    typedef logic src_t;
    localparam src_t SRC_INST = 1'b0;
    localparam src_t SRC_DATA = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD_I = 2'd1,
        HOLD_D = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic              wr;
        logic [SIZE_W-1:0] size;
        logic [STRB_W-1:0] wstrb;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } sram_req_t;

endpackage

// File: rtl/arb_order_fifo.sv
// 1-bit wide order FIFO remembering which side issued each accepted request.
// DEPTH must be a power of two so the pointers wrap on their own.
module arb_order_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic push,
    input  logic push_src,
    input  logic pop,
    output logic head,
    output logic full,
    output logic empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic          mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push_en;
    logic          pop_en;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    // A push at full is only safe when a pop frees the head slot in the same cycle.
    assign pop_en  = pop & ~empty;
    assign push_en = push & (~full | pop_en);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_en && !pop_en)      count_q <= count_q + 1'b1;
            else if (pop_en && !push_en) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q] <= push_src;
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one sram-like port between fetch and data sides: fixed data priority,
// grant held until address accept, responses routed back in issue order.
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int OUTSTANDING = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [SIZE_W-1:0] inst_size,
    input  logic [STRB_W-1:0] inst_wstrb,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [SIZE_W-1:0] data_size,
    input  logic [STRB_W-1:0] data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [SIZE_W-1:0] mem_size,
    output logic [STRB_W-1:0] mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err_unexp
);
    arb_state_e state_q, state_d;
    logic       err_q, err_d;
    logic       grant_vld;
    src_t       grant_src;
    logic       accept;
    logic       resp_vld;
    logic       fifo_head, fifo_full, fifo_empty;
    sram_req_t  inst_pkt, data_pkt, mem_pkt;

    assign inst_pkt = {inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata};
    assign data_pkt = {data_wr, data_size, data_wstrb, data_addr, data_wdata};

    always_comb begin
        grant_vld = 1'b0;
        grant_src = SRC_INST;
        state_d   = state_q;
        unique case (state_q)
            IDLE: begin
                if (!fifo_full) begin
                    if (data_req) begin
                        grant_vld = 1'b1;
                        grant_src = SRC_DATA;
                    end else if (inst_req) begin
                        grant_vld = 1'b1;
                    end
                end
                if (grant_vld && !mem_addr_ok)
                    state_d = (grant_src == SRC_DATA) ? HOLD_D : HOLD_I;
            end
            // A dropped request in HOLD is a pipeline flush: release without a push.
            HOLD_I: begin
                grant_vld = inst_req;
                if (!inst_req || mem_addr_ok) state_d = IDLE;
            end
            HOLD_D: begin
                grant_vld = data_req;
                grant_src = SRC_DATA;
                if (!data_req || mem_addr_ok) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (!resetn) grant_vld = 1'b0;
    end

    assign mem_pkt = (grant_src == SRC_DATA) ? data_pkt : inst_pkt;
    assign mem_req = grant_vld;
    assign {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata} = mem_pkt;

    assign accept       = grant_vld & mem_addr_ok;
    assign inst_addr_ok = accept & (grant_src == SRC_INST);
    assign data_addr_ok = accept & (grant_src == SRC_DATA);

    assign resp_vld     = resetn & mem_data_ok & ~fifo_empty;
    assign inst_data_ok = resp_vld & (fifo_head == SRC_INST);
    assign data_data_ok = resp_vld & (fifo_head == SRC_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;
    assign err_unexp    = err_q;

    assign err_d = err_q | (mem_data_ok & fifo_empty);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    arb_order_fifo #(.DEPTH(OUTSTANDING)) u_order_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push     (accept),
        .push_src (grant_src),
        .pop      (resp_vld),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: directed scenarios plus random traffic, all
// checked against a transaction-level model (issue-order queue + held source).
module tb_sram_bus_arbiter;
    localparam int OUT = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [3:0]  inst_wstrb, data_wstrb;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic        err_unexp;

    always #5 clk = ~clk;

    sram_bus_arbiter #(.OUTSTANDING(OUT)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .err_unexp(err_unexp)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: 0 = no held grant, 1 = fetch held, 2 = data held.
    int hold  = 0;
    bit mq[$];          // issue-order queue of sources, 1 = data side
    bit m_err = 1'b0;
    bit acc_i = 1'b0;
    bit acc_d = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_in();
        inst_req = 1'b0; data_req = 1'b0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    endtask

    // Called just after a rising edge with inputs already driven.
    task automatic cycle();
        int g;
        int dst;
        bit unexp;
        #1;
        g = 0;
        if (resetn) begin
            if (hold == 0) begin
                if (mq.size() < OUT) g = data_req ? 2 : (inst_req ? 1 : 0);
            end else if (hold == 1) begin
                g = inst_req ? 1 : 0;
            end else begin
                g = data_req ? 2 : 0;
            end
        end
        chk("mem_req", 32'(mem_req), 32'(g != 0));
        if (g != 0) begin
            chk("mem_addr", mem_addr, (g == 2) ? data_addr : inst_addr);
            chk("mem_wdata", mem_wdata, (g == 2) ? data_wdata : inst_wdata);
            chk("mem_ctl", 32'({mem_wr, mem_size, mem_wstrb}),
                (g == 2) ? 32'({data_wr, data_size, data_wstrb}) : 32'({inst_wr, inst_size, inst_wstrb}));
        end
        acc_i = (g == 1) && mem_addr_ok;
        acc_d = (g == 2) && mem_addr_ok;
        chk("inst_addr_ok", 32'(inst_addr_ok), 32'(acc_i));
        chk("data_addr_ok", 32'(data_addr_ok), 32'(acc_d));
        dst = 0;
        unexp = 1'b0;
        if (resetn && mem_data_ok) begin
            if (mq.size() > 0) dst = mq[0] ? 2 : 1;
            else unexp = 1'b1;
        end
        chk("inst_data_ok", 32'(inst_data_ok), 32'(dst == 1));
        chk("data_data_ok", 32'(data_data_ok), 32'(dst == 2));
        if (dst == 1) chk("inst_rdata", inst_rdata, mem_rdata);
        if (dst == 2) chk("data_rdata", data_rdata, mem_rdata);
        chk("err_unexp", 32'(err_unexp), 32'(m_err));
        if (acc_i || acc_d) $display("accept src=%s addr=%h", acc_d ? "data" : "inst", mem_addr);
        if (dst != 0)       $display("resp   dst=%s rdata=%h", (dst == 2) ? "data" : "inst", mem_rdata);
        @(posedge clk);
        if (!resetn) begin
            mq.delete();
            hold  = 0;
            m_err = 1'b0;
        end else begin
            if (dst != 0) void'(mq.pop_front());
            if (unexp) m_err = 1'b1;
            if (acc_i || acc_d) mq.push_back(acc_d);
            hold = (g != 0 && !mem_addr_ok) ? g : 0;
        end
        #1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            idle_in();
            mem_data_ok = 1'b1;
            mem_rdata = $urandom;
            cycle();
        end
        mem_data_ok = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        idle_in();
        inst_wr = 1'b0; data_wr = 1'b0;
        inst_size = 2'd2; data_size = 2'd2;
        inst_wstrb = 4'hf; data_wstrb = 4'hf;
        inst_addr = '0; data_addr = '0; inst_wdata = '0; data_wdata = '0;
        mem_rdata = '0;
        @(posedge clk); #1;
        cycle();
        inst_req = 1'b1;
        #1 chk("rst_mem_req", 32'(mem_req), 32'(0));
        cycle();
        resetn = 1'b1;

        // Single fetch: accepted at once, answered next cycle.
        idle_in();
        inst_req = 1'b1; inst_addr = 32'h1c00_0000; mem_addr_ok = 1'b1;
        #1 chk("tp1_inst_addr_ok", 32'(inst_addr_ok), 32'(1));
        cycle();
        idle_in();
        mem_data_ok = 1'b1; mem_rdata = 32'h0280_0c0c;
        #1 chk("tp1_inst_data_ok", 32'(inst_data_ok), 32'(1));
        chk("tp1_inst_rdata", inst_rdata, 32'h0280_0c0c);
        chk("tp1_data_data_ok", 32'(data_data_ok), 32'(0));
        cycle();

        // Conflict: data wins, fetch follows.
        idle_in();
        inst_req = 1'b1; inst_addr = 32'h1c00_0040;
        data_req = 1'b1; data_addr = 32'h1c01_0000; mem_addr_ok = 1'b1;
        #1 chk("tp2_mem_addr", mem_addr, 32'h1c01_0000);
        cycle();
        data_req = 1'b0;
        #1 chk("tp2_inst_addr_ok", 32'(inst_addr_ok), 32'(1));
        cycle();
        drain(2);

        // Held fetch grant is not stolen by a later data request.
        idle_in();
        inst_req = 1'b1; inst_addr = 32'h1c00_0080;
        cycle();
        data_req = 1'b1; data_addr = 32'h1c01_0010;
        for (int i = 0; i < 2; i++) begin
            #1 chk("tp3_mem_addr_held", mem_addr, 32'h1c00_0080);
            cycle();
        end
        mem_addr_ok = 1'b1;
        #1 chk("tp3_inst_accept", 32'(inst_addr_ok), 32'(1));
        cycle();
        inst_req = 1'b0;
        #1 chk("tp3_data_accept", 32'(data_addr_ok), 32'(1));
        cycle();
        drain(2);

        // Full FIFO blocks grants; push+pop keeps occupancy.
        idle_in();
        inst_req = 1'b1; mem_addr_ok = 1'b1;
        inst_addr = 32'h1c00_0100; cycle();
        inst_addr = 32'h1c00_0104; cycle();
        inst_addr = 32'h1c00_0108;
        #1 chk("tp4_full_mem_req", 32'(mem_req), 32'(0));
        cycle();
        mem_data_ok = 1'b1;
        #1 chk("tp4_full_pop_mem_req", 32'(mem_req), 32'(0));
        cycle();
        #1 chk("tp4_push_pop_accept", 32'(inst_addr_ok), 32'(1));
        cycle();
        mem_data_ok = 1'b0; inst_addr = 32'h1c00_010c;
        cycle();
        inst_addr = 32'h1c00_0110;
        #1 chk("tp4_refull_mem_req", 32'(mem_req), 32'(0));
        cycle();
        drain(2);

        // Interleaved sources, responses routed in issue order.
        idle_in();
        inst_req = 1'b1; inst_addr = 32'h1c00_0200; mem_addr_ok = 1'b1; cycle();
        inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h1c01_0200; cycle();
        idle_in(); mem_data_ok = 1'b1; mem_rdata = 32'hA;
        #1 chk("tp5_resp_a_inst", 32'(inst_data_ok), 32'(1));
        cycle();
        idle_in(); inst_req = 1'b1; inst_addr = 32'h1c00_0204; mem_addr_ok = 1'b1; cycle();
        idle_in(); mem_data_ok = 1'b1; mem_rdata = 32'hB;
        #1 chk("tp5_resp_b_data", 32'(data_data_ok), 32'(1));
        cycle();
        mem_rdata = 32'hC;
        #1 chk("tp5_resp_c_inst", 32'(inst_data_ok), 32'(1));
        chk("tp5_resp_c_rdata", inst_rdata, 32'hC);
        cycle();

        // Unexpected response, then a one-cycle reset clears it.
        idle_in(); mem_data_ok = 1'b1;
        #1 chk("tp6_no_data_ok", 32'(inst_data_ok | data_data_ok), 32'(0));
        cycle();
        idle_in();
        chk("tp6_err_set", 32'(err_unexp), 32'(1));
        resetn = 1'b0; cycle(); resetn = 1'b1;
        chk("tp6_err_clr", 32'(err_unexp), 32'(0));
        inst_req = 1'b1; mem_addr_ok = 1'b1; inst_addr = 32'h1c00_0300; cycle();
        inst_addr = 32'h1c00_0304;
        #1 chk("tp6_second_accept", 32'(inst_addr_ok), 32'(1));
        cycle();
        drain(2);

        // Random traffic with flushes and occasional resets.
        idle_in();
        for (int c = 0; c < 600; c++) begin
            resetn = ($urandom_range(99) != 0);
            if (inst_req && !acc_i) begin
                if ($urandom_range(15) == 0) inst_req = 1'b0;
            end else begin
                inst_req = 1'($urandom_range(1)); inst_addr = $urandom; inst_wdata = $urandom;
                inst_size = 2'($urandom_range(3)); inst_wstrb = 4'($urandom);
            end
            if (data_req && !acc_d) begin
                if ($urandom_range(15) == 0) data_req = 1'b0;
            end else begin
                data_req = 1'($urandom_range(1)); data_addr = $urandom; data_wdata = $urandom;
                data_wr = 1'($urandom_range(1)); data_size = 2'($urandom_range(3));
                data_wstrb = 4'($urandom);
            end
            mem_addr_ok = 1'($urandom_range(1));
            mem_data_ok = (mq.size() > 0) ? 1'($urandom_range(1)) : 1'b0;
            mem_rdata = $urandom;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
